i2c_tx_fifo: RTL and testbench

I2C_TX_FIFO -- requirements
Module: i2c_tx_fifo

---
 rtl/i2c_tx_fifo.sv | 104 ++++++++++
 tb/tb_i2c_tx_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_tx_fifo.sv
// Transmit FIFO between the APB bridge and the I2C core; 2**AWIDTH words, registered read.
// Sticky OVERFLOW/UNDERFLOW flags are built only when I2C_TX_FIFO_ERR_FLAGS_EN is defined.
module i2c_tx_fifo #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 3
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              WR_ENA,
   input  logic [DWIDTH-1:0] WRITE_DATA_ON_TX,
   input  logic              RD_ENA,
   output logic [DWIDTH-1:0] RD_DATA,
   output logic              TX_EMPTY,
   output logic              TX_FULL,
   output logic [AWIDTH:0]   COUNT,
   input  logic              CLR_ERR,
   output logic              OVERFLOW,
   output logic              UNDERFLOW,
   output logic              ERROR
);

   localparam int unsigned DEPTH = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] FULL_COUNT = {1'b1, {AWIDTH{1'b0}}};

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic [AWIDTH:0]   count;
   logic              pop_ok;
   logic              wr_ok;

   assign TX_EMPTY = (count == '0);
   assign TX_FULL  = (count == FULL_COUNT);
   assign COUNT    = count;

   // A write into a full FIFO is still accepted when a pop frees the slot in the same cycle.
   assign pop_ok = RD_ENA && !TX_EMPTY;
   assign wr_ok  = WR_ENA && (!TX_FULL || pop_ok);

   always_ff @(posedge PCLK) begin
      if (wr_ok) begin
         mem[wr_ptr] <= WRITE_DATA_ON_TX;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         RD_DATA <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            RD_DATA <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         case ({wr_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
   logic ovf_event;
   logic udf_event;

   assign ovf_event = WR_ENA && !wr_ok;
   assign udf_event = RD_ENA && TX_EMPTY;

   // A new error event in the same cycle as CLR_ERR wins over the clear.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (ovf_event) begin
            OVERFLOW <= 1'b1;
         end else if (CLR_ERR) begin
            OVERFLOW <= 1'b0;
         end
         if (udf_event) begin
            UNDERFLOW <= 1'b1;
         end else if (CLR_ERR) begin
            UNDERFLOW <= 1'b0;
         end
      end
   end

   assign ERROR = OVERFLOW | UNDERFLOW;
`else
   logic clr_err_unused;

   assign clr_err_unused = CLR_ERR;
   assign OVERFLOW       = 1'b0;
   assign UNDERFLOW      = 1'b0;
   assign ERROR          = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Bench for i2c_tx_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_i2c_tx_fifo;

   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          WR_ENA = 1'b0;
   logic [DW-1:0] WRITE_DATA_ON_TX = '0;
   logic          RD_ENA = 1'b0;
   logic [DW-1:0] RD_DATA;
   logic          TX_EMPTY;
   logic          TX_FULL;
   logic [AW:0]   COUNT;
   logic          CLR_ERR = 1'b0;
   logic          OVERFLOW;
   logic          UNDERFLOW;
   logic          ERROR;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_rd;
   bit            m_ovf;
   bit            m_udf;

   i2c_tx_fifo #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .WR_ENA(WR_ENA),
      .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX),
      .RD_ENA(RD_ENA),
      .RD_DATA(RD_DATA),
      .TX_EMPTY(TX_EMPTY),
      .TX_FULL(TX_FULL),
      .COUNT(COUNT),
      .CLR_ERR(CLR_ERR),
      .OVERFLOW(OVERFLOW),
      .UNDERFLOW(UNDERFLOW),
      .ERROR(ERROR)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst_n, input bit wr, input logic [DW-1:0] d,
                             input bit rd, input bit clr);
      bit pop;
      bit push;
      if (!rst_n) begin
         m_q.delete();
         m_rd  = '0;
         m_ovf = 0;
         m_udf = 0;
      end else begin
         pop  = rd && (m_q.size() > 0);
         push = wr && ((m_q.size() < DEPTH) || pop);
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
         if (clr) begin
            m_ovf = 0;
            m_udf = 0;
         end
         if (wr && !push) m_ovf = 1;
         if (rd && m_q.size() == 0) m_udf = 1;
`endif
         if (pop) m_rd = m_q.pop_front();
         if (push) m_q.push_back(d);
      end
   endtask

   task automatic cycle(input bit rst_n, input bit wr, input logic [DW-1:0] d,
                        input bit rd, input bit clr);
      @(negedge PCLK);
      PRESETn          = rst_n;
      WR_ENA           = wr;
      WRITE_DATA_ON_TX = d;
      RD_ENA           = rd;
      CLR_ERR          = clr;
      @(posedge PCLK);
      model_step(rst_n, wr, d, rd, clr);
      #1;
      check("count", 64'(COUNT), 64'(m_q.size()));
      check("empty", 64'(TX_EMPTY), 64'(m_q.size() == 0));
      check("full", 64'(TX_FULL), 64'(m_q.size() == DEPTH));
      check("rd_data", 64'(RD_DATA), 64'(m_rd));
      check("overflow", 64'(OVERFLOW), 64'(m_ovf));
      check("underflow", 64'(UNDERFLOW), 64'(m_udf));
      check("error", 64'(ERROR), 64'(m_ovf | m_udf));
   endtask

   task automatic idle();
      cycle(1, 0, '0, 0, 0);
   endtask

   initial begin
      // reset state
      cycle(0, 0, '0, 0, 0);
      check("rst_empty", 64'(TX_EMPTY), 64'd1);
      check("rst_rd", 64'(RD_DATA), 64'd0);

      // three words in, three out, first write right after reset
      cycle(1, 1, 32'h11, 0, 0);
      cycle(1, 1, 32'h22, 0, 0);
      cycle(1, 1, 32'h33, 0, 0);
      cycle(1, 0, '0, 1, 0);
      check("pop0", 64'(RD_DATA), 64'h11);
      cycle(1, 0, '0, 1, 0);
      check("pop1", 64'(RD_DATA), 64'h22);
      cycle(1, 0, '0, 1, 0);
      check("pop2", 64'(RD_DATA), 64'h33);
      idle();
      check("end_empty", 64'(TX_EMPTY), 64'd1);

      // fill, drop a write while full, drain
      for (int i = 0; i < DEPTH; i++) cycle(1, 1, 32'hA0 + 32'(i), 0, 0);
      check("fill_full", 64'(TX_FULL), 64'd1);
      check("fill_cnt", 64'(COUNT), 64'd8);
      cycle(1, 1, 32'hFF, 0, 0);
      check("drop_cnt", 64'(COUNT), 64'd8);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, 0, '0, 1, 0);
         check("drain", 64'(RD_DATA), 64'hA0 + 64'(i));
      end
      cycle(1, 0, '0, 0, 1);

      // simultaneous write and pop while full
      for (int i = 0; i < DEPTH; i++) cycle(1, 1, 32'hB0 + 32'(i), 0, 0);
      cycle(1, 1, 32'hB8, 1, 0);
      check("wrrd_full_cnt", 64'(COUNT), 64'd8);
      check("wrrd_full_rd", 64'(RD_DATA), 64'hB0);
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, '0, 1, 0);
      check("last_b8", 64'(RD_DATA), 64'hB8);

      // pop when empty, then clear; also write+pop while empty
      cycle(1, 0, '0, 1, 0);
      check("udf_rd_hold", 64'(RD_DATA), 64'hB8);
      cycle(1, 0, '0, 0, 1);
      check("clr_error", 64'(ERROR), 64'd0);
      cycle(1, 1, 32'h5A, 1, 0);
      check("empty_wrrd_cnt", 64'(COUNT), 64'd1);
      check("empty_wrrd_rd", 64'(RD_DATA), 64'hB8);
      cycle(1, 0, '0, 1, 1);
      cycle(1, 0, '0, 1, 1);   // clear and fresh underflow in one cycle

      // streaming write/pop pairs across pointer wrap
      cycle(1, 0, '0, 0, 1);
      cycle(1, 1, 32'd0, 0, 0);
      for (int i = 1; i < 20; i++) begin
         cycle(1, 1, 32'(i), 1, 0);
         check("stream_rd", 64'(RD_DATA), 64'(i - 1));
         check("stream_le1", 64'(COUNT <= 1), 64'd1);
      end
      cycle(1, 0, '0, 1, 0);
      check("stream_last", 64'(RD_DATA), 64'd19);

      // reset mid-operation overrides a write
      for (int i = 0; i < 5; i++) cycle(1, 1, 32'hC0 + 32'(i), 0, 0);
      cycle(0, 1, 32'hEE, 1, 0);
      check("midrst_cnt", 64'(COUNT), 64'd0);
      check("midrst_empty", 64'(TX_EMPTY), 64'd1);
      cycle(1, 1, 32'h77, 0, 0);
      cycle(1, 0, '0, 1, 0);
      check("post_rst_rd", 64'(RD_DATA), 64'h77);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         bit r_rst;
         bit r_wr;
         bit r_rd;
         bit r_clr;
         r_rst = ($urandom_range(0, 99) != 0);
         r_wr  = ($urandom_range(0, 99) < 55);
         r_rd  = ($urandom_range(0, 99) < 45);
         r_clr = ($urandom_range(0, 19) == 0);
         cycle(r_rst, r_wr, $urandom, r_rd, r_clr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
